bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 34 +++
 rtl/bin2bcd_lane.sv | 59 +++++
 rtl/bin2bcd_seq.sv | 96 +++++++++
 tb/tb_bin2bcd_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and elaboration-time helpers for the sequential
// binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << (i - 1)) < n) begin
                w = i;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bin2bcd_lane.sv
// One channel of the converter: input shift register, BCD scratch with the
// add-3 adjust, overflow latch and the registered result.
module bin2bcd_lane
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                       iClock,
    input  logic                       iResetn,
    input  logic                       load,
    input  logic                       shift,
    input  logic                       capture,
    input  logic [BIN_W-1:0]           bin,
    output logic [DIGITS*NIBBLE_W-1:0] bcd,
    output logic                       overflow
);

    localparam int SCR_W = DIGITS * NIBBLE_W;

    logic [BIN_W-1:0] sreg;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] adj;
    logic             ovf_q;

    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[d*NIBBLE_W +: NIBBLE_W] > 4'd4) begin
                adj[d*NIBBLE_W +: NIBBLE_W] = scratch[d*NIBBLE_W +: NIBBLE_W] + 4'd3;
            end
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            sreg     <= '0;
            scratch  <= '0;
            ovf_q    <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                sreg    <= bin;
                scratch <= '0;
                // Full-precision compare: the threshold may be wider than the input.
                ovf_q   <= (32'(bin) >= pow10(DIGITS));
            end else if (shift) begin
                scratch <= {adj[SCR_W-2:0], sreg[BIN_W-1]};
                sreg    <= sreg << 1;
            end
            if (capture) begin
                bcd      <= ovf_q ? {DIGITS{4'h9}} : scratch;
                overflow <= ovf_q;
            end
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-channel sequential double-dabble converter: one control FSM and
// iteration counter shared by CHANNELS lane instances.
//
// state | meaning
// IDLE  | waiting for iStart; a start edge loads every lane
// SHIFT | one adjust+shift per edge; the edge after the last shift captures
// DONE  | results valid, oDone high for this single cycle
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 2
) (
    input  logic                                iClock,
    input  logic                                iResetn,
    input  logic                                iStart,
    input  logic [CHANNELS*BIN_W-1:0]           iBin,
    output logic [CHANNELS*DIGITS*NIBBLE_W-1:0] oBCD,
    output logic [CHANNELS-1:0]                 oOverflow,
    output logic                                oBusy,
    output logic                                oDone
);

    localparam int                 CNT_W = clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BIN_W);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             load;
    logic             shift;
    logic             capture;

    always_comb begin
        load    = (state == IDLE) && iStart;
        shift   = (state == SHIFT) && (count != LAST);
        capture = (state == SHIFT) && (count == LAST);
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state <= IDLE;
            count <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        state <= SHIFT;
                        count <= '0;
                        oBusy <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (count == LAST) begin
                        state <= DONE;
                        oDone <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                    oBusy <= 1'b0;
                    oDone <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    oBusy <= 1'b0;
                    oDone <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        bin2bcd_lane #(
            .BIN_W  (BIN_W),
            .DIGITS (DIGITS)
        ) u_lane (
            .iClock   (iClock),
            .iResetn  (iResetn),
            .load     (load),
            .shift    (shift),
            .capture  (capture),
            .bin      (iBin[c*BIN_W +: BIN_W]),
            .bcd      (oBCD[c*DIGITS*NIBBLE_W +: DIGITS*NIBBLE_W]),
            .overflow (oOverflow[c])
        );
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations against a decimal-arithmetic
// reference, with timing, restart-ignore and asynchronous reset checks.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_ab;
    logic [15:0] bin_ab;
    logic [23:0] bcd_a;
    logic [1:0]  ovf_a;
    logic        busy_a, done_a;
    logic [15:0] bcd_b;
    logic [1:0]  ovf_b;
    logic        busy_b, done_b;

    logic        start_c;
    logic [15:0] bin_c;
    logic [19:0] bcd_c;
    logic [0:0]  ovf_c;
    logic        busy_c, done_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .CHANNELS(2)) dut_a (
        .iClock(clk), .iResetn(rst_n), .iStart(start_ab), .iBin(bin_ab),
        .oBCD(bcd_a), .oOverflow(ovf_a), .oBusy(busy_a), .oDone(done_a));

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .CHANNELS(2)) dut_b (
        .iClock(clk), .iResetn(rst_n), .iStart(start_ab), .iBin(bin_ab),
        .oBCD(bcd_b), .oOverflow(ovf_b), .oBusy(busy_b), .oDone(done_b));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .CHANNELS(1)) dut_c (
        .iClock(clk), .iResetn(rst_n), .iStart(start_c), .iBin(bin_c),
        .oBCD(bcd_c), .oOverflow(ovf_c), .oBusy(busy_c), .oDone(done_c));

    // Decimal digits by repeated division; saturates to all nines.
    function automatic logic [63:0] ref_bcd(input int v, input int digits);
        logic [63:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < digits; d++) begin
            if (v >= 10 ** digits) r[4*d +: 4] = 4'h9;
            else                   r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_ab(input int v0, input int v1, input bit repulse);
        logic [63:0] exp_a, exp_b;
        logic [1:0]  exp_oa, exp_ob;
        int lat, nb, nd;
        exp_a  = ref_bcd(v0, 3) | (ref_bcd(v1, 3) << 12);
        exp_b  = ref_bcd(v0, 2) | (ref_bcd(v1, 2) << 8);
        exp_oa = {v1 >= 1000, v0 >= 1000};
        exp_ob = {v1 >= 100, v0 >= 100};
        @(negedge clk);
        bin_ab   = {v1[7:0], v0[7:0]};
        start_ab = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_ab = 1'b0;
        bin_ab   = 16'($urandom);
        lat = -1; nb = 0; nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_a) break;
            nb++;
            if (done_a) begin
                nd++;
                if (lat < 0) begin
                    lat = i;
                    check("bcd_a", 64'(bcd_a), exp_a);
                    check("ovf_a", 64'(ovf_a), 64'(exp_oa));
                    check("bcd_b", 64'(bcd_b), exp_b);
                    check("ovf_b", 64'(ovf_b), 64'(exp_ob));
                    check("done_b", 64'(done_b), 64'd1);
                end
            end
            if (repulse && i == 3) begin
                start_ab = 1'b1;
                bin_ab   = 16'($urandom);
            end
            if (repulse && i == 4) start_ab = 1'b0;
            @(negedge clk);
        end
        check("latency_a", 64'(lat), 64'd9);
        check("busy_cycles_a", 64'(nb), 64'd10);
        check("done_pulses_a", 64'(nd), 64'd1);
        check("busy_end_a", 64'(busy_a), 64'd0);
        repeat (3) @(negedge clk);
        check("hold_bcd_a", 64'(bcd_a), exp_a);
        check("hold_bcd_b", 64'(bcd_b), exp_b);
        check("idle_busy_a", 64'(busy_a), 64'd0);
    endtask

    task automatic run_c(input int v);
        int lat, nb;
        @(negedge clk);
        bin_c   = v[15:0];
        start_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        bin_c   = 16'($urandom);
        lat = -1; nb = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy_c) break;
            nb++;
            if (done_c && lat < 0) begin
                lat = i;
                check("bcd_c", 64'(bcd_c), ref_bcd(v, 5));
                check("ovf_c", 64'(ovf_c), 64'd0);
            end
            @(negedge clk);
        end
        check("latency_c", 64'(lat), 64'd17);
        check("busy_cycles_c", 64'(nb), 64'd18);
    endtask

    initial begin
        rst_n    = 1'b0;
        start_ab = 1'b0;
        start_c  = 1'b0;
        bin_ab   = '0;
        bin_c    = '0;
        #23;
        check("rst_bcd_a", 64'(bcd_a), 64'd0);
        check("rst_ovf_a", 64'(ovf_a), 64'd0);
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_done_a", 64'(done_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_ab(255, 0, 1'b0);
        run_ab(42, 200, 1'b0);
        run_ab(99, 100, 1'b0);
        run_ab(123, 99, 1'b0);
        run_ab(250, 7, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_ab(int'($urandom_range(255)), int'($urandom_range(255)), 1'b0);
        end

        run_c(65535);
        run_c(0);
        for (int k = 0; k < 3; k++) begin
            run_c(int'($urandom_range(65535)));
        end

        // Asynchronous reset in the middle of a shift sequence.
        @(negedge clk);
        bin_ab   = {8'd88, 8'd77};
        start_ab = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_ab = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bcd_a", 64'(bcd_a), 64'd0);
        check("arst_ovf_b", 64'(ovf_b), 64'd0);
        check("arst_busy_a", 64'(busy_a), 64'd0);
        check("arst_done_a", 64'(done_a), 64'd0);
        check("arst_bcd_b", 64'(bcd_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_ab(7, 31, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
